instr_decode: RTL and testbench
===============================

Name:
instr_decode

Overview:
- Execute stage of the byte-serial CPU: takes one fetched 32-bit instruction from the instruction receiver under a run/ok handshake and executes it.
- Reads the 32x32 register file and the byte-wide main memory, writes results back, and redirects the PC for jumps.
- Raises a one-cycle interrupt request for the INT instruction.
- Exposes its FSM state on `test_decoding` for debug.

Parameters:
- None. Widths are fixed: 19-bit memory address, 8-bit memory data, 5-bit register index.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  32  instruction word, valid when run rises.
- run  in  1  execute request (level).
- MMemory_rdata  in  8  main-memory read data.
- MMemory_wdata  out  8  main-memory write data.
- REG_rdata  in  32  register-file read data.
- REG_wdata  out  32  register-file write data.
- ok  out  1  instruction complete (level).
- MMemory_raddr  out  19  memory read address.
- MMemory_waddr  out  19  memory write address.
- MMemory_wren  out  1  memory write enable.
- REG_raddr  out  5  register read index.
- REG_waddr  out  5  register write index.
- REG_wren  out  1  register write enable.
- PC_decode_wdata  out  32  new PC value.
- PC_decode_wren  out  1  PC write enable.
- intr  out  1  interrupt request pulse.
- test_decoding  out  5  current FSM state code.

Behaviour:
- Reset (async, `rst_n`=0): state IDLE.
  - All outputs 0.
  - Internal operand and result registers cleared.
  - Reset mid-instruction aborts it with no further writes.
- Instruction fields:
  - op = instr[31:27]
  - rd = instr[26:22]
  - rs = instr[21:17]
  - imm = instr[16:0]
  - simm = sign-extended imm (32 bits)
  - zimm = zero-extended imm (32 bits)
- Opcodes (unlisted values execute as NOP):
  - 0x01 LI: R[rd] = simm
  - 0x02 MOV: R[rd] = R[rs]
  - 0x03 ADD: R[rd] = R[rd] + R[rs]
  - 0x04 SUB: R[rd] = R[rd] - R[rs]
  - 0x05 AND, 0x06 OR, 0x07 XOR: R[rd] = R[rd] op R[rs]
  - 0x08 ADDI: R[rd] = R[rd] + simm
  - 0x09 LB: R[rd] = zero-extended mem[(R[rs]+simm)[18:0]]
  - 0x0A SB: mem[(R[rs]+simm)[18:0]] = R[rd][7:0]
  - 0x0B JMP: PC = zimm
  - 0x0C BEQZ: if R[rd]==0 then PC = zimm
  - 0x0D INT: intr pulse
- Arithmetic: 32-bit, modulo 2^32, no flags. R0 is an ordinary register.
- Read latency (RF and memory): data is sampled at the second rising edge after the address is registered.
- FSM, with `test_decoding` codes:
  - IDLE(0): `ok`=0. On `run`=1, latch `instr`, REG_raddr<=rs, go to RS1.
  - RS1(1): hold; go to RS2.
  - RS2(2): A<=REG_rdata, REG_raddr<=rd, go to RD1.
  - RD1(3): hold; go to RD2.
  - RD2(4): B<=REG_rdata, go to EXEC.
  - EXEC(5): compute result/address. Next state: LB goes to MR1; ALU/LI/MOV/ADDI go to WB; all others go to DONE.
  - MR1(6): MMemory_raddr held at the address; go to MR2.
  - MR2(7): capture byte; go to WB.
  - WB(8): REG_wren=1, REG_waddr=rd, REG_wdata=result; go to DONE.
  - DONE(9): `ok`=1. Stay while `run`=1; go to IDLE when `run`=0.
- Write strobes are combinational from state plus latched op, one cycle wide:
  - `MMemory_wren` in EXEC for SB; `MMemory_waddr`/`MMemory_wdata` valid in that cycle.
  - `PC_decode_wren` in EXEC for JMP, or for BEQZ when taken; `PC_decode_wdata` = zimm.
  - `intr` in EXEC for INT.
  - Otherwise all enables are 0.
- Latency, counted from the edge that samples `run`=1 to the edge that sets `ok`:
  - ALU/LI/MOV/ADDI: 6 edges.
  - LB: 8 edges.
  - SB/JMP/BEQZ/INT/NOP: 5 edges.
- Handshake rules:
  - `instr` is latched, so changes to `instr` or a drop of `run` mid-operation are ignored and the instruction completes.
  - `run` held high in DONE does not re-execute; `ok` stays high.
  - A new instruction starts only after a return to IDLE.
- Outputs not strobed keep their last values. Only the enables are defined when idle.

Test Plan:
- Preload R3=5, R4=7; run ADD (op 0x03, rd=3, rs=4) -> REG_wren one cycle with REG_waddr=3, REG_wdata=12; `ok` rises 6 edges after run; `ok` holds until run=0, then test_decoding=0.
- SUB with R1=0, R2=1 -> REG_wdata=0xFFFFFFFF. LI rd=5 imm=0x1FFFF -> REG_wdata=0xFFFFFFFF.
- R2=0x7FFFF, mem[0x00000]=0xA5; LB rd=6 rs=2 simm=1 -> MMemory_raddr=0x00000 (wrap); REG_wdata=0x000000A5; `ok` after 8 edges.
- R1=0x100, R7=0x1234; SB rd=7 rs=1 imm=0x10 -> single MMemory_wren cycle, MMemory_waddr=0x00110, MMemory_wdata=0x34; no REG_wren.
- JMP imm=0x40 -> PC_decode_wren for 1 cycle, PC_decode_wdata=0x40. BEQZ with R[rd]=3 -> no PC write. INT -> `intr` high exactly 1 cycle. Undefined op 0x1F -> no strobes, `ok` after 5 edges.
- Assert `rst_n`=0 during RD1 of an ADD -> immediate IDLE, all outputs 0, no REG_wren. With run held high afterwards, the instruction re-executes from IDLE.

Source files
------------

// File: rtl/instr_decode_if.sv
// Bus bundle between the instruction receiver / memories and the execute stage.
// The master side feeds instructions and read data; the slave side is instr_decode.
`timescale 1ns/1ps
interface instr_decode_if;
   logic [31:0] instr;
   logic        run;
   logic        ok;
   logic [7:0]  MMemory_rdata;
   logic [7:0]  MMemory_wdata;
   logic [18:0] MMemory_raddr;
   logic [18:0] MMemory_waddr;
   logic        MMemory_wren;
   logic [31:0] REG_rdata;
   logic [31:0] REG_wdata;
   logic [4:0]  REG_raddr;
   logic [4:0]  REG_waddr;
   logic        REG_wren;
   logic [31:0] PC_decode_wdata;
   logic        PC_decode_wren;
   logic        intr;
   logic [4:0]  test_decoding;

   modport master (
      output instr, run, MMemory_rdata, REG_rdata,
      input  ok, MMemory_wdata, MMemory_raddr, MMemory_waddr, MMemory_wren,
             REG_wdata, REG_raddr, REG_waddr, REG_wren,
             PC_decode_wdata, PC_decode_wren, intr, test_decoding
   );

   modport slave (
      input  instr, run, MMemory_rdata, REG_rdata,
      output ok, MMemory_wdata, MMemory_raddr, MMemory_waddr, MMemory_wren,
             REG_wdata, REG_raddr, REG_waddr, REG_wren,
             PC_decode_wdata, PC_decode_wren, intr, test_decoding
   );
endinterface

// File: rtl/instr_decode.sv
// Execute stage of the byte-serial CPU: fetches operands from the register file,
// executes one latched instruction, and writes results to RF, memory or PC.
`timescale 1ns/1ps
module instr_decode (
   input  logic          clk,
   input  logic          rst_n,
   instr_decode_if.slave bus
);

   typedef enum logic [4:0] {
      S_IDLE = 5'd0,
      S_RS1  = 5'd1,
      S_RS2  = 5'd2,
      S_RD1  = 5'd3,
      S_RD2  = 5'd4,
      S_EXEC = 5'd5,
      S_MR1  = 5'd6,
      S_MR2  = 5'd7,
      S_WB   = 5'd8,
      S_DONE = 5'd9
   } state_t;

   typedef enum logic [4:0] {
      OP_LI   = 5'h01,
      OP_MOV  = 5'h02,
      OP_ADD  = 5'h03,
      OP_SUB  = 5'h04,
      OP_AND  = 5'h05,
      OP_OR   = 5'h06,
      OP_XOR  = 5'h07,
      OP_ADDI = 5'h08,
      OP_LB   = 5'h09,
      OP_SB   = 5'h0A,
      OP_JMP  = 5'h0B,
      OP_BEQZ = 5'h0C,
      OP_INT  = 5'h0D
   } op_t;

   state_t      state;
   logic [31:0] ir;
   logic [31:0] a_q;      // R[rs]
   logic [31:0] b_q;      // R[rd]
   logic        ok_q;
   logic [4:0]  reg_raddr_q;
   logic [4:0]  reg_waddr_q;
   logic [31:0] reg_wdata_q;
   logic [18:0] mem_raddr_q;
   logic [18:0] mem_waddr_q;
   logic [7:0]  mem_wdata_q;
   logic [31:0] pc_wdata_q;

   logic [4:0]  op;
   logic [4:0]  rd;
   logic [4:0]  rs;
   logic [31:0] simm;
   logic [31:0] zimm;
   logic [18:0] mem_addr;
   logic [31:0] alu_res;
   logic        writes_reg;

   assign op       = ir[31:27];
   assign rd       = ir[26:22];
   assign rs       = ir[21:17];
   assign simm     = {{15{ir[16]}}, ir[16:0]};
   assign zimm     = {15'd0, ir[16:0]};
   assign mem_addr = a_q[18:0] + simm[18:0];

   // NOTE: every output of a combinational block gets a default before the
   // case, otherwise unlisted opcodes would infer a latch.
   always_comb begin
      alu_res    = '0;
      writes_reg = 1'b1;
      case (op)
         OP_LI:   alu_res = simm;
         OP_MOV:  alu_res = a_q;
         OP_ADD:  alu_res = b_q + a_q;
         OP_SUB:  alu_res = b_q - a_q;
         OP_AND:  alu_res = b_q & a_q;
         OP_OR:   alu_res = b_q | a_q;
         OP_XOR:  alu_res = b_q ^ a_q;
         OP_ADDI: alu_res = b_q + simm;
         default: writes_reg = 1'b0;
      endcase
   end

   // NOTE: all state here uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         ir          <= '0;
         a_q         <= '0;
         b_q         <= '0;
         ok_q        <= 1'b0;
         reg_raddr_q <= '0;
         reg_waddr_q <= '0;
         reg_wdata_q <= '0;
         mem_raddr_q <= '0;
         mem_waddr_q <= '0;
         mem_wdata_q <= '0;
         pc_wdata_q  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               ok_q <= 1'b0;
               if (bus.run) begin
                  ir          <= bus.instr;
                  reg_raddr_q <= bus.instr[21:17];
                  state       <= S_RS1;
               end
            end
            S_RS1: state <= S_RS2;
            S_RS2: begin
               a_q         <= bus.REG_rdata;
               reg_raddr_q <= rd;
               state       <= S_RD1;
            end
            S_RD1: state <= S_RD2;
            S_RD2: begin
               b_q <= bus.REG_rdata;
               // Store address/data and jump target must be stable throughout EXEC.
               if (op == OP_SB) begin
                  mem_waddr_q <= mem_addr;
                  mem_wdata_q <= bus.REG_rdata[7:0];
               end
               if (op == OP_JMP || op == OP_BEQZ) pc_wdata_q <= zimm;
               state <= S_EXEC;
            end
            S_EXEC: begin
               if (op == OP_LB) begin
                  mem_raddr_q <= mem_addr;
                  state       <= S_MR1;
               end else if (writes_reg) begin
                  reg_wdata_q <= alu_res;
                  reg_waddr_q <= rd;
                  state       <= S_WB;
               end else begin
                  ok_q  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_MR1: state <= S_MR2;
            S_MR2: begin
               reg_wdata_q <= {24'd0, bus.MMemory_rdata};
               reg_waddr_q <= rd;
               state       <= S_WB;
            end
            S_WB: begin
               ok_q  <= 1'b1;
               state <= S_DONE;
            end
            S_DONE: begin
               if (!bus.run) begin
                  ok_q  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.ok              = ok_q;
   assign bus.REG_raddr       = reg_raddr_q;
   assign bus.REG_waddr       = reg_waddr_q;
   assign bus.REG_wdata       = reg_wdata_q;
   assign bus.REG_wren        = (state == S_WB);
   assign bus.MMemory_raddr   = mem_raddr_q;
   assign bus.MMemory_waddr   = mem_waddr_q;
   assign bus.MMemory_wdata   = mem_wdata_q;
   assign bus.MMemory_wren    = (state == S_EXEC) && (op == OP_SB);
   assign bus.PC_decode_wdata = pc_wdata_q;
   assign bus.PC_decode_wren  = (state == S_EXEC) &&
                                ((op == OP_JMP) || ((op == OP_BEQZ) && (b_q == 32'd0)));
   assign bus.intr            = (state == S_EXEC) && (op == OP_INT);
   assign bus.test_decoding   = state;

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode: RF/memory models with two-edge read latency and
// a scoreboard of expected write strobes compared against observed ones.
`timescale 1ns/1ps
module tb_instr_decode;

   localparam logic [4:0] OP_LI = 5'h01, OP_ADD = 5'h03, OP_SUB = 5'h04, OP_XOR = 5'h07,
                          OP_ADDI = 5'h08, OP_LB = 5'h09, OP_SB = 5'h0A, OP_JMP = 5'h0B,
                          OP_BEQZ = 5'h0C, OP_INT = 5'h0D, OP_BAD = 5'h1F;

   typedef enum logic [1:0] {K_REG, K_MEM, K_PC, K_INT} kind_t;
   typedef struct {
      kind_t       kind;
      logic [31:0] addr;
      logic [31:0] data;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n;
   instr_decode_if bus ();

   instr_decode u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   logic [31:0] rf  [32];
   logic [7:0]  mem [524288];
   logic        pl_reg = 1'b0, pl_mem = 1'b0;
   logic [31:0] pl_addr = '0, pl_data = '0;

   // Registered read port: address seen at one edge, data presented after the next.
   always @(posedge clk) begin
      bus.REG_rdata     <= rf[bus.REG_raddr];
      bus.MMemory_rdata <= mem[bus.MMemory_raddr];
      if (bus.REG_wren)     rf[bus.REG_waddr]      <= bus.REG_wdata;
      if (bus.MMemory_wren) mem[bus.MMemory_waddr] <= bus.MMemory_wdata;
      if (pl_reg)           rf[pl_addr[4:0]]       <= pl_data;
      if (pl_mem)           mem[pl_addr[18:0]]     <= pl_data[7:0];
   end

   ev_t exp_q[$];
   ev_t obs_q[$];

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.REG_wren)       obs_q.push_back('{K_REG, 32'(bus.REG_waddr), bus.REG_wdata});
         if (bus.MMemory_wren)   obs_q.push_back('{K_MEM, 32'(bus.MMemory_waddr), 32'(bus.MMemory_wdata)});
         if (bus.PC_decode_wren) obs_q.push_back('{K_PC, 32'd0, bus.PC_decode_wdata});
         if (bus.intr)           obs_q.push_back('{K_INT, 32'd0, 32'd0});
      end
   end

   int n_vec  = 0;
   int n_miss = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [16:0] imm);
      return {op, rd, rs, imm};
   endfunction

   task automatic poke_reg(input int idx, input logic [31:0] val);
      @(negedge clk);
      pl_reg = 1'b1; pl_addr = 32'(idx); pl_data = val;
      @(negedge clk);
      pl_reg = 1'b0;
   endtask

   task automatic poke_mem(input logic [18:0] addr, input logic [7:0] val);
      @(negedge clk);
      pl_mem = 1'b1; pl_addr = 32'(addr); pl_data = 32'(val);
      @(negedge clk);
      pl_mem = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_strobes"}, 32'({bus.ok, bus.REG_wren, bus.MMemory_wren, bus.PC_decode_wren, bus.intr}), 32'd0);
      chk({tag, "_state"},   32'(bus.test_decoding), 32'd0);
      chk({tag, "_regw"},    bus.REG_wdata, 32'd0);
      chk({tag, "_pcw"},     bus.PC_decode_wdata, 32'd0);
      chk({tag, "_idx"},     32'({bus.MMemory_wdata, bus.REG_raddr, bus.REG_waddr}), 32'd0);
      chk({tag, "_maddr"},   32'({bus.MMemory_raddr, 13'd0}) | 32'(bus.MMemory_waddr), 32'd0);
   endtask

   // Counts edges from the one sampling run=1 up to the one that raises ok.
   task automatic wait_ok(input int lat, input string tag);
      int e = 0;
      @(posedge clk);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         e++;
         if (bus.ok === 1'b1) break;
      end
      chk({tag, "_latency"}, 32'(e), 32'(lat));
   endtask

   task automatic finish_instr(input string tag);
      repeat (2) begin
         @(negedge clk);
         chk({tag, "_hold"}, 32'({bus.ok, bus.test_decoding}), 32'({1'b1, 5'd9}));
      end
      bus.run = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, "_idle"}, 32'({bus.ok, bus.test_decoding}), 32'd0);
      chk({tag, "_nevents"}, 32'(obs_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         ev_t e = exp_q.pop_front();
         ev_t o = obs_q.pop_front();
         chk({tag, "_kind"}, 32'(o.kind), 32'(e.kind));
         chk({tag, "_addr"}, o.addr, e.addr);
         chk({tag, "_data"}, o.data, e.data);
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic run_instr(input logic [31:0] ins, input int lat, input string tag);
      @(negedge clk);
      bus.instr = ins;
      bus.run   = 1'b1;
      wait_ok(lat, tag);
      bus.instr = ~ins;   // must be ignored once latched
      finish_instr(tag);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.run = 1'b0;
      bus.instr = '0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      poke_reg(3, 32'd5);
      poke_reg(4, 32'd7);
      exp_q.push_back('{K_REG, 32'd3, 32'd12});
      run_instr(enc(OP_ADD, 5'd3, 5'd4, 17'd0), 6, "add");

      poke_reg(1, 32'd0);
      poke_reg(2, 32'd1);
      exp_q.push_back('{K_REG, 32'd1, 32'hFFFF_FFFF});
      run_instr(enc(OP_SUB, 5'd1, 5'd2, 17'd0), 6, "sub");

      exp_q.push_back('{K_REG, 32'd5, 32'hFFFF_FFFF});
      run_instr(enc(OP_LI, 5'd5, 5'd0, 17'h1FFFF), 6, "li");

      poke_reg(2, 32'h0007_FFFF);
      poke_mem(19'h00000, 8'hA5);
      exp_q.push_back('{K_REG, 32'd6, 32'h0000_00A5});
      run_instr(enc(OP_LB, 5'd6, 5'd2, 17'd1), 8, "lb");
      chk("lb_raddr", 32'(bus.MMemory_raddr), 32'd0);

      poke_reg(1, 32'h0000_0100);
      poke_reg(7, 32'h0000_1234);
      exp_q.push_back('{K_MEM, 32'h0000_0110, 32'h0000_0034});
      run_instr(enc(OP_SB, 5'd7, 5'd1, 17'h10), 5, "sb");

      exp_q.push_back('{K_PC, 32'd0, 32'h0000_0040});
      run_instr(enc(OP_JMP, 5'd0, 5'd0, 17'h40), 5, "jmp");

      poke_reg(8, 32'd3);
      run_instr(enc(OP_BEQZ, 5'd8, 5'd0, 17'h77), 5, "beqz_nt");

      poke_reg(9, 32'd0);
      exp_q.push_back('{K_PC, 32'd0, 32'h0001_0055});
      run_instr(enc(OP_BEQZ, 5'd9, 5'd0, 17'h10055), 5, "beqz_t");

      exp_q.push_back('{K_INT, 32'd0, 32'd0});
      run_instr(enc(OP_INT, 5'd0, 5'd0, 17'd0), 5, "int");

      run_instr(enc(OP_BAD, 5'd3, 5'd4, 17'h1ABCD), 5, "nop");

      // Reset during RD1 of an ADD (R3=12, R4=7), then re-run with run held high.
      @(negedge clk);
      bus.instr = enc(OP_ADD, 5'd3, 5'd4, 17'd0);
      bus.run   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mid_state", 32'(bus.test_decoding), 32'd3);
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back('{K_REG, 32'd3, 32'd19});
      wait_ok(6, "rerun");
      finish_instr("rerun");

      exp_q.push_back('{K_REG, 32'd3, 32'd18});
      run_instr(enc(OP_ADDI, 5'd3, 5'd0, 17'h1FFFF), 6, "addi");

      exp_q.push_back('{K_REG, 32'd3, 32'h0000_0015});
      run_instr(enc(OP_XOR, 5'd3, 5'd4, 17'd0), 6, "xor");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
